// File: rtl/eeg_oram_bank_responder.sv
// eeg_oram_bank_responder: single-port ORAM bank with alternating write/read arbitration,
// a 1-cycle read pipeline and a credit-managed read-data output FIFO.
module eeg_oram_bank_responder #(
    parameter int ORAM_ADD_MW = 10,
    parameter int ORAM_DAT_DW = 4,
    parameter int OBUF_DEPTH  = 3
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   BNK_MTOO_DAT_VLD,
    input  logic                   BNK_MTOO_DAT_LST,
    output logic                   BNK_MTOO_DAT_RDY,
    input  logic [ORAM_ADD_MW-1:0] BNK_MTOO_DAT_ADD,
    input  logic [ORAM_DAT_DW-1:0] BNK_MTOO_DAT_DAT,
    input  logic                   BNK_MTOO_ADD_VLD,
    input  logic                   BNK_MTOO_ADD_LST,
    output logic                   BNK_MTOO_ADD_RDY,
    input  logic [ORAM_ADD_MW-1:0] BNK_MTOO_ADD_ADD,
    output logic                   BNK_OTOM_DAT_VLD,
    output logic                   BNK_OTOM_DAT_LST,
    input  logic                   BNK_OTOM_DAT_RDY,
    output logic [ORAM_DAT_DW-1:0] BNK_OTOM_DAT_DAT,
    output logic                   BNK_WR_DONE
);
    localparam int PW = $clog2(OBUF_DEPTH) + 1;
    localparam int IW = PW - 1;
    localparam logic [PW-1:0] LAST = PW'(OBUF_DEPTH - 1);

    typedef enum logic {PRI_WR, PRI_RD} pri_t;

    pri_t                   pri;
    logic [ORAM_DAT_DW-1:0] mem [2**ORAM_ADD_MW];
    logic [ORAM_DAT_DW-1:0] fifo_dat [2**IW];
    logic [2**IW-1:0]       fifo_lst;
    logic [PW-1:0]          occ, occ_n, wr_ptr, rd_ptr, rd_ptr_n;
    logic [ORAM_DAT_DW-1:0] rd_dat, head_dat;
    logic                   rd_inflight, rd_lst, head_lst;
    logic                   credit_ok, rd_req, wr_fire, rd_fire, pop;

    // Credit counts words already buffered plus the one in the RAM pipeline; pops are
    // deliberately ignored so RDY never depends on the downstream RDY.
    always_comb begin
        credit_ok        = (occ + PW'(rd_inflight)) < PW'(OBUF_DEPTH);
        rd_req           = BNK_MTOO_ADD_VLD && credit_ok;
        BNK_MTOO_DAT_RDY = !rd_req || pri == PRI_WR;
        BNK_MTOO_ADD_RDY = credit_ok && (!BNK_MTOO_DAT_VLD || pri == PRI_RD);
        wr_fire          = BNK_MTOO_DAT_VLD && BNK_MTOO_DAT_RDY;
        rd_fire          = BNK_MTOO_ADD_VLD && BNK_MTOO_ADD_RDY;
        pop              = BNK_OTOM_DAT_VLD && BNK_OTOM_DAT_RDY;
        rd_ptr_n         = !pop ? rd_ptr : rd_ptr == LAST ? '0 : rd_ptr + 1'b1;
        occ_n            = occ + PW'(rd_inflight) - PW'(pop);
        head_dat         = rd_inflight && rd_ptr_n == wr_ptr ? rd_dat : fifo_dat[rd_ptr_n[IW-1:0]];
        head_lst         = rd_inflight && rd_ptr_n == wr_ptr ? rd_lst : fifo_lst[rd_ptr_n[IW-1:0]];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pri              <= PRI_WR;
            occ              <= '0;
            wr_ptr           <= '0;
            rd_ptr           <= '0;
            rd_inflight      <= 1'b0;
            BNK_WR_DONE      <= 1'b0;
            BNK_OTOM_DAT_VLD <= 1'b0;
            BNK_OTOM_DAT_LST <= 1'b0;
            BNK_OTOM_DAT_DAT <= '0;
        end else begin
            if (rd_req && BNK_MTOO_DAT_VLD)
                pri <= pri == PRI_WR ? PRI_RD : PRI_WR;
            occ    <= occ_n;
            rd_ptr <= rd_ptr_n;
            if (rd_inflight)
                wr_ptr <= wr_ptr == LAST ? '0 : wr_ptr + 1'b1;
            rd_inflight      <= rd_fire;
            BNK_WR_DONE      <= wr_fire && BNK_MTOO_DAT_LST;
            BNK_OTOM_DAT_VLD <= occ_n != '0;
            if (occ_n != '0) begin
                BNK_OTOM_DAT_DAT <= head_dat;
                BNK_OTOM_DAT_LST <= head_lst;
            end
        end
    end

    // RAM and FIFO storage carry no reset so bank contents survive a reset.
    always_ff @(posedge clk) begin
        if (wr_fire)
            mem[BNK_MTOO_DAT_ADD] <= BNK_MTOO_DAT_DAT;
        if (rd_fire) begin
            rd_dat <= mem[BNK_MTOO_ADD_ADD];
            rd_lst <= BNK_MTOO_ADD_LST;
        end
        if (rd_inflight) begin
            fifo_dat[wr_ptr[IW-1:0]] <= rd_dat;
            fifo_lst[wr_ptr[IW-1:0]] <= rd_lst;
        end
    end
endmodule

// File: tb/tb_eeg_oram_bank_responder.sv
// tb_eeg_oram_bank_responder: scoreboard bench with a memory-array reference model.
module tb_eeg_oram_bank_responder;
    localparam int AW = 10;
    localparam int DW = 4;

    typedef struct packed {logic [DW-1:0] d; logic l;} exp_t;

    logic          clk = 1'b0, rst_n = 1'b0;
    logic          dat_vld = 1'b0, dat_lst = 1'b0, add_vld = 1'b0, add_lst = 1'b0, otom_rdy = 1'b0;
    logic [AW-1:0] dat_add = '0, add_add = '0;
    logic [DW-1:0] dat_dat = '0;
    logic          dat_rdy, add_rdy, otom_vld, otom_lst, wr_done;
    logic [DW-1:0] otom_dat;

    int            checks = 0, failures = 0;
    logic [DW-1:0] ref_mem [1024];
    exp_t          expq[$];
    exp_t          e;
    logic          wd_exp = 1'b0, held = 1'b0, prev_lst = 1'b0;
    logic [DW-1:0] prev_dat = '0;

    eeg_oram_bank_responder dut (
        .clk(clk), .rst_n(rst_n),
        .BNK_MTOO_DAT_VLD(dat_vld), .BNK_MTOO_DAT_LST(dat_lst), .BNK_MTOO_DAT_RDY(dat_rdy),
        .BNK_MTOO_DAT_ADD(dat_add), .BNK_MTOO_DAT_DAT(dat_dat),
        .BNK_MTOO_ADD_VLD(add_vld), .BNK_MTOO_ADD_LST(add_lst), .BNK_MTOO_ADD_RDY(add_rdy),
        .BNK_MTOO_ADD_ADD(add_add),
        .BNK_OTOM_DAT_VLD(otom_vld), .BNK_OTOM_DAT_LST(otom_lst), .BNK_OTOM_DAT_RDY(otom_rdy),
        .BNK_OTOM_DAT_DAT(otom_dat), .BNK_WR_DONE(wr_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endtask

    // Input side: accepted writes update the model, accepted reads enqueue the expected word.
    always @(negedge clk) begin
        if (!rst_n) wd_exp = 1'b0;
        else begin
            chk("wr_done", wr_done, wd_exp);
            chk("arb_excl", dat_vld && dat_rdy && add_vld && add_rdy, 0);
            wd_exp = dat_vld && dat_rdy && dat_lst;
            if (dat_vld && dat_rdy) ref_mem[dat_add] = dat_dat;
            if (add_vld && add_rdy) expq.push_back(exp_t'{ref_mem[add_add], add_lst});
        end
    end

    // Output side: pops and compares each delivered word, and checks stalled words stay put.
    always @(negedge clk) begin
        if (!rst_n) held = 1'b0;
        else begin
            if (held) begin
                chk("hold_vld", otom_vld, 1);
                chk("hold_payload", {otom_lst, otom_dat}, {prev_lst, prev_dat});
            end
            if (otom_vld && otom_rdy) begin
                if (expq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_word got=%0h exp=none", otom_dat);
                end else begin
                    e = expq.pop_front();
                    chk("rd_dat", otom_dat, e.d);
                    chk("rd_lst", otom_lst, e.l);
                end
            end
            held = otom_vld && !otom_rdy;
            prev_dat = otom_dat;
            prev_lst = otom_lst;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int d, input bit l, output int tries);
        bit ok = 1'b0;
        tries = 0;
        dat_vld = 1'b1; dat_add = AW'(a); dat_dat = DW'(d); dat_lst = l;
        while (tries < 100 && !ok) begin
            @(negedge clk);
            ok = dat_rdy;
            tries++;
            cyc();
        end
        dat_vld = 1'b0; dat_lst = 1'b0;
        chk("wr_accept", ok, 1);
    endtask

    task automatic rd(input int a, input bit l, output int tries);
        bit ok = 1'b0;
        tries = 0;
        add_vld = 1'b1; add_add = AW'(a); add_lst = l;
        while (tries < 100 && !ok) begin
            @(negedge clk);
            ok = add_rdy;
            tries++;
            cyc();
        end
        add_vld = 1'b0; add_lst = 1'b0;
        chk("rd_accept", ok, 1);
    endtask

    task automatic drain();
        int c = 0;
        otom_rdy = 1'b1;
        while (c < 50 && expq.size() != 0) begin
            cyc();
            c++;
        end
        chk("drain", expq.size(), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, n, v, d;
        logic [1:0] g;
        logic wacc = 1'b0, racc = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_vld", otom_vld, 0);
        chk("rst_lst", otom_lst, 0);
        chk("rst_dat", otom_dat, 0);
        chk("rst_wr_done", wr_done, 0);
        chk("rst_dat_rdy", dat_rdy, 1);
        chk("rst_add_rdy_idle", add_rdy, 1);
        dat_vld = 1'b1;
        #1 chk("rst_add_rdy_wr", add_rdy, 0);
        dat_vld = 1'b0;
        cyc();
        rst_n = 1'b1;
        cyc();

        for (int i = 0; i < 32; i++) wr(i, int'($urandom_range(0, 15)), i == 31, t);

        // Test 1: write then read with exact latency
        otom_rdy = 1'b1;
        wr(5, 9, 1'b1, t);
        rd(5, 1'b1, t);
        @(negedge clk);
        chk("t1_vld_early", otom_vld, 0);
        cyc();
        @(negedge clk);
        chk("t1_vld", otom_vld, 1);
        chk("t1_dat", otom_dat, 9);
        chk("t1_lst", otom_lst, 1);
        cyc();
        drain();

        // Test 2: back-to-back reads at full throughput
        for (int i = 0; i < 8; i++) begin
            add_vld = 1'b1; add_add = AW'(i); add_lst = i == 7;
            @(negedge clk);
            chk("t2_add_rdy", add_rdy, 1);
            cyc();
        end
        add_vld = 1'b0; add_lst = 1'b0;
        cyc();
        cyc();
        chk("t2_throughput", expq.size(), 0);
        drain();

        // Test 3: credit limits outstanding reads to the FIFO depth
        otom_rdy = 1'b0;
        n = 0;
        for (int c = 0; c < 8; c++) begin
            add_vld = 1'b1; add_add = AW'(8 + n); add_lst = n == 4;
            @(negedge clk);
            if (add_rdy) n++;
            cyc();
        end
        chk("t3_accepted", n, 3);
        @(negedge clk);
        chk("t3_rdy_low", add_rdy, 0);
        cyc();
        otom_rdy = 1'b1;
        for (int c = 0; c < 30 && n < 5; c++) begin
            add_add = AW'(8 + n); add_lst = n == 4;
            @(negedge clk);
            if (add_rdy) n++;
            cyc();
        end
        add_vld = 1'b0; add_lst = 1'b0;
        chk("t3_rest", n, 5);
        drain();

        // Test 4: contention alternates grants starting with write
        dat_vld = 1'b1; add_vld = 1'b1;
        for (int i = 0; i < 6; i++) begin
            dat_add = AW'(16 + i); dat_dat = DW'($urandom_range(0, 15)); dat_lst = i == 5;
            add_add = AW'(i); add_lst = i == 5;
            @(negedge clk);
            g = {dat_vld && dat_rdy, add_vld && add_rdy};
            chk("t4_grant", g, i % 2 == 0 ? 2'b10 : 2'b01);
            cyc();
        end
        dat_vld = 1'b0; add_vld = 1'b0; dat_lst = 1'b0; add_lst = 1'b0;
        drain();

        // Test 5: read right after write to the same address
        d = (int'(ref_mem[20]) + 5) % 16;
        wr(20, d, 1'b1, t);
        chk("t5_wr_first_try", t, 1);
        rd(20, 1'b1, t);
        chk("t5_rd_first_try", t, 1);
        drain();

        // Test 6: reset with words buffered and in flight
        otom_rdy = 1'b0;
        rd(24, 1'b0, t);
        rd(25, 1'b0, t);
        rd(26, 1'b1, t);
        rst_n = 1'b0;
        expq.delete();
        @(negedge clk);
        chk("t6_vld", otom_vld, 0);
        chk("t6_dat", otom_dat, 0);
        chk("t6_lst", otom_lst, 0);
        chk("t6_wr_done", wr_done, 0);
        cyc();
        cyc();
        rst_n = 1'b1;
        otom_rdy = 1'b1;
        v = 0;
        repeat (4) begin
            @(negedge clk);
            v += int'(otom_vld);
            cyc();
        end
        chk("t6_no_stale", v, 0);
        rd(24, 1'b0, t);
        rd(25, 1'b0, t);
        rd(26, 1'b1, t);
        drain();

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            if (!dat_vld || wacc) begin
                dat_vld = 1'($urandom_range(0, 1));
                dat_add = AW'($urandom_range(0, 31));
                dat_dat = DW'($urandom_range(0, 15));
                dat_lst = 1'($urandom_range(0, 1));
            end
            if (!add_vld || racc) begin
                add_vld = 1'($urandom_range(0, 1));
                add_add = AW'($urandom_range(0, 31));
                add_lst = 1'($urandom_range(0, 1));
            end
            otom_rdy = $urandom_range(0, 3) != 0;
            @(negedge clk);
            wacc = dat_vld && dat_rdy;
            racc = add_vld && add_rdy;
            cyc();
        end
        dat_vld = 1'b0; add_vld = 1'b0;
        drain();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
